// File: rtl/output_assignment_pkg.sv
// Shared constants and types for the registered adder.
// Configuration: OUTPUT_ASSIGNMENT_SAT_EN selects saturating instead of wrapping results.
package output_assignment_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef struct packed {
        logic                     carry;
        logic [WIDTH_DEFAULT-1:0] value;
    } result_t;

    localparam logic [WIDTH_DEFAULT-1:0] SAT_ONES = '1;

endpackage

// File: rtl/output_assignment_adder.sv
// Purely combinational unsigned adder producing the WIDTH-bit sum and its carry-out.
module output_assignment_adder
    import output_assignment_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] full_sum;

    // One extra bit keeps the carry-out without a separate compare.
    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b};
    end

    assign sum   = full_sum[WIDTH-1:0];
    assign carry = full_sum[WIDTH];

endmodule

// File: rtl/output_assignment.sv
// Registered adder top: sum/carry from the adder, optional saturation, output registers.
// Configuration: define OUTPUT_ASSIGNMENT_SAT_EN to clamp y to all-ones on carry-out.
module output_assignment
    import output_assignment_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             ovf,
    output logic             y_valid
);

    // No handshake: a and b are taken on every rising edge and the result appears
    // on y/ovf one edge later; y_valid marks results computed after reset release.

    logic [WIDTH-1:0] sum;
    logic             carry;

    logic [WIDTH-1:0] y_d, y_q;
    logic             ovf_d, ovf_q;
    logic             y_valid_d, y_valid_q;

    output_assignment_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a     (a),
        .b     (b),
        .sum   (sum),
        .carry (carry)
    );

    always_comb begin
        y_d       = sum;
        ovf_d     = carry;
        y_valid_d = 1'b1;
`ifdef OUTPUT_ASSIGNMENT_SAT_EN
        if (carry) begin
            y_d = '1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= '0;
            ovf_q     <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            ovf_q     <= ovf_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign ovf     = ovf_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_output_assignment.sv
// Scoreboard bench for output_assignment: directed vectors plus random operands vs a reference model.
module tb_output_assignment;
    import output_assignment_pkg::*;

    localparam int W = WIDTH_DEFAULT;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         ovf;
    logic         y_valid;

    result_t exp_q[$];
    int      errors = 0;
    int      checks = 0;

    // clock/reset block
    always #5 clk = ~clk;

    output_assignment #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .y       (y),
        .ovf     (ovf),
        .y_valid (y_valid)
    );

    // Reference model: plain wide arithmetic on the unsigned operands.
    function automatic result_t ref_model(input logic [W-1:0] x, input logic [W-1:0] z);
        result_t         r;
        longint unsigned s;
        longint unsigned limit;
        limit   = 64'd1 << W;
        s       = longint'(x) + longint'(z);
        r.carry = (s >= limit);
`ifdef OUTPUT_ASSIGNMENT_SAT_EN
        r.value = r.carry ? W'(limit - 64'd1) : W'(s);
`else
        r.value = W'(s % limit);
`endif
        return r;
    endfunction

    task automatic check(input string name,
                         input logic [W-1:0] gy, input logic go, input logic gv,
                         input logic [W-1:0] ey, input logic eo, input logic ev);
        checks++;
        if (gy !== ey || go !== eo || gv !== ev) begin
            errors++;
            $display("FAIL %s: got y=%h ovf=%b valid=%b, want y=%h ovf=%b valid=%b",
                     name, gy, go, gv, ey, eo, ev);
        end
    endtask

    // driver task: drive operands away from the active edge, push the expected result
    task automatic apply(input logic [W-1:0] x, input logic [W-1:0] z);
        @(negedge clk);
        a = x;
        b = z;
        exp_q.push_back(ref_model(x, z));
    endtask

    // monitor: every edge outside reset presents a result; compare against the queue head
    initial begin
        result_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stream", y, ovf, y_valid, e.value, e.carry, 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst = 1'b0;
        a   = '0;
        b   = '0;

        // asynchronous reset before any clock edge
        #1;
        rst = 1'b1;
        a   = 32'h1234_5678;
        b   = 32'h0000_0001;
        #1;
        check("reset_async", y, ovf, y_valid, '0, 1'b0, 1'b0);

        // outputs hold reset values across an edge while rst is high
        @(posedge clk);
        #1;
        check("reset_hold", y, ovf, y_valid, '0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;

        // latency, stream, overflow and max no-carry vectors
        apply(32'h0000_0001, 32'h0000_1000);
        apply(32'h0000_0000, 32'h0000_0000);
        apply(32'h0000_1000, 32'h0000_0000);
        apply(32'h1000_0000, 32'h0000_0000);
        apply(32'h0000_1000, 32'h1000_0000);
        apply(32'h1000_0000, 32'h0000_0001);
        apply(32'hFFFF_FFFF, 32'h0000_0001);
        apply(32'hFFFF_FFFE, 32'h0000_0001);
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // mid-operation reset while y holds 0x10001000
        apply(32'h0000_1000, 32'h1000_0000);
        @(posedge clk);
        #3;
        check("pre_reset", y, ovf, y_valid, 32'h1000_1000, 1'b0, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_reset", y, ovf, y_valid, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("valid_return", y, ovf, y_valid, 32'h1000_1000, 1'b0, 1'b1);

        // random operands with bias toward carry boundaries
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = ~ra + 1'b1;
                2: rb = ~ra;
                default: rb = W'($urandom_range(0, 15));
            endcase
            apply(ra, rb);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_assignment.md
OUTPUT_ASSIGNMENT -- requirements
Module: output_assignment

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter WIDTH SHALL default to 32 and set the operand and result width.
REQ-003 Port clk SHALL be a 1-bit input: the single clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be a 1-bit input: asynchronous, active-high reset.
REQ-005 Port a SHALL be a WIDTH-bit input: operand A, sampled every clk edge.
REQ-006 Port b SHALL be a WIDTH-bit input: operand B, sampled every clk edge.
REQ-007 Port y SHALL be a WIDTH-bit output: registered result.
REQ-008 Port ovf SHALL be a 1-bit output: registered carry-out/overflow flag for the result currently on y.
REQ-009 Port y_valid SHALL be a 1-bit output: high once y holds a result computed after reset release.

Function
REQ-010 On each rising clk edge with rst low, y SHALL load (a + b) mod 2^WIDTH, unsigned, with one-cycle latency.
REQ-011 ovf SHALL load the carry-out of the unsigned WIDTH-bit addition a + b on the same edge as y.
REQ-012 y_valid SHALL go high on the first rising edge after rst deasserts and stay high until the next reset.
REQ-013 There is no handshake or enable: inputs SHALL be accepted on every clock edge, back-to-back.
REQ-014 y, ovf and y_valid SHALL change only on a clk edge or on reset assertion, never combinationally from a or b.
REQ-015 Operands with disjoint set bits (e.g. a=0x00000001, b=0x00001000) SHALL give y equal to their bitwise OR, with ovf=0.
REQ-016 Boundary a=0xFFFFFFFF, b=0x00000001 SHALL give y=0x00000000 and ovf=1 (wrap-around build).

Reset
REQ-017 Asserting rst SHALL immediately, without waiting for a clock, force y=0, ovf=0 and y_valid=0.
REQ-018 While rst is high, the outputs SHALL hold these reset values regardless of clk, a or b.
REQ-019 Reset asserted mid-stream SHALL discard the in-flight result; operation resumes per REQ-010 and REQ-012 after release.

Configuration
REQ-020 Macro OUTPUT_ASSIGNMENT_SAT_EN SHALL select saturating addition: on carry-out, y SHALL load all-ones (0xFFFFFFFF for WIDTH=32) and ovf SHALL be 1.
REQ-021 Without OUTPUT_ASSIGNMENT_SAT_EN, y SHALL wrap modulo 2^WIDTH per REQ-010; ovf behaviour is identical in both builds.

Structure
REQ-022 Package output_assignment_pkg SHALL hold the WIDTH default constant, the result typedef (value plus carry), and the all-ones saturation constant.
REQ-023 A combinational sub-module output_assignment_adder SHALL compute the sum and carry-out; the top level SHALL contain only the saturation mux and output registers.

Verification
REQ-024 Reset test: assert rst with a=0x12345678, b=1, no clock edges -> y=0, ovf=0, y_valid=0 immediately.
REQ-025 Latency test: after reset release, apply a=0x00000001, b=0x00001000 -> y=0x00001001, ovf=0, y_valid=1 exactly one edge later.
REQ-026 Stream test: apply back-to-back vectors (0,0), (0x1000,0), (0x10000000,0), (0x1000,0x10000000), (0x10000000,1) -> y=0, 0x1000, 0x10000000, 0x10001000, 0x10000001 on consecutive edges.
REQ-027 Overflow test: a=0xFFFFFFFF, b=1 -> y=0, ovf=1 (default build); y=0xFFFFFFFF, ovf=1 (SAT_EN build).
REQ-028 Mid-operation reset test: pulse rst between edges while y=0x10001000 -> y=0 and y_valid=0 at once; y_valid returns high on the first edge after release.
REQ-029 Max no-carry test: a=0xFFFFFFFE, b=1 -> y=0xFFFFFFFF, ovf=0 in both builds.
